// File: rtl/wb_commit_multi_pkg.sv
// Shared constants and helpers for the multi-lane writeback stage.
`define WB_DBG_ENTRY_W(xlen) (2 * (xlen) + 1 + 5)

package wb_commit_multi_pkg;

    localparam int LANES_MAX  = 4;
    localparam int ECODE_W    = 8;
    localparam int CSR_ADDR_W = 14;
    localparam int REG_ADDR_W = 5;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Debug trace entry layout: {pc, gr_we, dest, result}.
    function automatic int dbg_entry_w(input int xlen);
        return `WB_DBG_ENTRY_W(xlen);
    endfunction

endpackage

// File: rtl/wb_commit_multi_dbg_fifo.sv
// Debug-trace FIFO: up to LANES pushes per cycle (lanes 0..push_cnt-1),
// one pop per cycle whenever non-empty. Head reads as zero when empty.
module wb_dbg_fifo
    import wb_commit_multi_pkg::*;
#(
    parameter int LANES = 2,
    parameter int DEPTH = 4,
    parameter int WIDTH = 70
) (
    input  logic                                clk,
    input  logic                                rstn,
    input  logic [clog2(LANES+1)-1:0]           push_cnt,
    input  logic [LANES-1:0][WIDTH-1:0]         push_data,
    output logic [clog2(DEPTH+1)-1:0]           count,
    output logic [WIDTH-1:0]                    head
);

    localparam int PTR_W = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);
    localparam int CNT_W = clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             pop;

    function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p, input int n);
        return PTR_W'((int'(p) + n) % DEPTH);
    endfunction

    assign pop  = (count != '0);
    assign head = pop ? mem[rd_ptr] : '0;

    // Pointer and occupancy update; a pop frees its slot only from the next cycle on.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= ptr_add(wr_ptr, int'(push_cnt));
            rd_ptr <= pop ? ptr_add(rd_ptr, 1) : rd_ptr;
            count  <= CNT_W'(int'(count) + int'(push_cnt) - (pop ? 1 : 0));
        end
    end

    // Entry storage, written in lane order starting at the write pointer.
    always_ff @(posedge clk) begin
        if (rstn) begin
            for (int i = 0; i < LANES; i++) begin
                if (i < int'(push_cnt)) begin
                    mem[ptr_add(wr_ptr, i)] <= push_data[i];
                end
            end
        end
    end

endmodule

// File: rtl/wb_commit_multi.sv
// Multi-lane writeback stage: registers a group from the memory stage and
// commits it in program order (RF ports, CSR/exception port, retire count),
// feeding retired instructions into a debug-trace FIFO.
module wb_commit_multi
    import wb_commit_multi_pkg::*;
#(
    parameter int LANES     = 2,
    parameter int XLEN      = 32,
    parameter int DBG_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rstn,
    output logic                            w_allowin,
    input  logic                            mw_valid,
    input  logic [LANES-1:0]                mw_lane_valid,
    input  logic [LANES*XLEN-1:0]           mw_pc,
    input  logic [LANES*XLEN-1:0]           mw_result,
    input  logic [LANES*XLEN-1:0]           mw_vaddr,
    input  logic [LANES-1:0]                mw_gr_we,
    input  logic [LANES*REG_ADDR_W-1:0]     mw_dest,
    input  logic [LANES-1:0]                mw_ex,
    input  logic [LANES*ECODE_W-1:0]        mw_ecode,
    input  logic [LANES-1:0]                mw_esubcode,
    input  logic                            mw_csr_we,
    input  logic [CSR_ADDR_W-1:0]           mw_csr_addr,
    input  logic [XLEN-1:0]                 mw_csr_wmask,
    input  logic [XLEN-1:0]                 mw_csr_wdata,
    input  logic                            ex_en,
    output logic [LANES-1:0]                rf_we,
    output logic [LANES*REG_ADDR_W-1:0]     rf_waddr,
    output logic [LANES*XLEN-1:0]           rf_wdata,
    output logic                            csr_ex,
    output logic [ECODE_W-1:0]              csr_ecode,
    output logic                            csr_esubcode,
    output logic [XLEN-1:0]                 csr_pc,
    output logic [XLEN-1:0]                 csr_vaddr,
    output logic                            csr_we,
    output logic [CSR_ADDR_W-1:0]           csr_addr,
    output logic [XLEN-1:0]                 csr_wmask,
    output logic [XLEN-1:0]                 csr_wdata,
    output logic [clog2(LANES+1)-1:0]       retire_cnt,
    output logic [XLEN-1:0]                 debug_wb_pc,
    output logic [3:0]                      debug_wb_rf_we,
    output logic [4:0]                      debug_wb_rf_wnum,
    output logic [XLEN-1:0]                 debug_wb_rf_wdata
);

    localparam int RC_W  = clog2(LANES + 1);
    localparam int CNT_W = clog2(DBG_DEPTH + 1);
    localparam int EW    = dbg_entry_w(XLEN);

    logic                        w_valid;
    logic [LANES-1:0]            w_lane_valid;
    logic [LANES*XLEN-1:0]       w_pc;
    logic [LANES*XLEN-1:0]       w_result;
    logic [LANES*XLEN-1:0]       w_vaddr;
    logic [LANES-1:0]            w_gr_we;
    logic [LANES*REG_ADDR_W-1:0] w_dest;
    logic [LANES-1:0]            w_ex;
    logic [LANES*ECODE_W-1:0]    w_ecode;
    logic [LANES-1:0]            w_esubcode;
    logic                        w_csr_we;
    logic [CSR_ADDR_W-1:0]       w_csr_addr;
    logic [XLEN-1:0]             w_csr_wmask;
    logic [XLEN-1:0]             w_csr_wdata;

    int                          ex_lane;
    int                          n_ret;
    logic [LANES-1:0]            retiring;
    logic [LANES-1:0]            shadowed;
    logic                        w_ready_go;
    logic                        fire;
    logic [CNT_W-1:0]            dbg_count;
    logic [EW-1:0]               dbg_head;
    logic [LANES-1:0][EW-1:0]    push_data;

    // Stage register; a flush beats capture and also clears the payload.
    always_ff @(posedge clk) begin
        if (!rstn || ex_en) begin
            w_valid      <= 1'b0;
            w_lane_valid <= '0;
            w_pc         <= '0;
            w_result     <= '0;
            w_vaddr      <= '0;
            w_gr_we      <= '0;
            w_dest       <= '0;
            w_ex         <= '0;
            w_ecode      <= '0;
            w_esubcode   <= '0;
            w_csr_we     <= 1'b0;
            w_csr_addr   <= '0;
            w_csr_wmask  <= '0;
            w_csr_wdata  <= '0;
        end else if (w_allowin) begin
            w_valid <= mw_valid;
            if (mw_valid) begin
                w_lane_valid <= mw_lane_valid;
                w_pc         <= mw_pc;
                w_result     <= mw_result;
                w_vaddr      <= mw_vaddr;
                w_gr_we      <= mw_gr_we;
                w_dest       <= mw_dest;
                w_ex         <= mw_ex;
                w_ecode      <= mw_ecode;
                w_esubcode   <= mw_esubcode;
                w_csr_we     <= mw_csr_we;
                w_csr_addr   <= mw_csr_addr;
                w_csr_wmask  <= mw_csr_wmask;
                w_csr_wdata  <= mw_csr_wdata;
            end
        end
    end

    // The oldest excepting lane bounds which lanes retire.
    always_comb begin
        ex_lane  = LANES;
        retiring = '0;
        n_ret    = 0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (w_lane_valid[i] && w_ex[i]) ex_lane = i;
        end
        for (int i = 0; i < LANES; i++) begin
            if (w_lane_valid[i] && (i < ex_lane)) begin
                retiring[i] = 1'b1;
                n_ret       = n_ret + 1;
            end
        end
    end

    // Only the registered FIFO count is credited; a same-cycle pop is not.
    assign w_ready_go = (DBG_DEPTH - int'(dbg_count)) >= n_ret;
    assign w_allowin  = !w_valid || w_ready_go;
    assign fire       = w_valid && w_ready_go;

    // A write is dropped when a younger retiring lane targets the same register.
    always_comb begin
        shadowed = '0;
        for (int i = 0; i < LANES; i++) begin
            for (int j = i + 1; j < LANES; j++) begin
                if (retiring[j] && w_gr_we[j] &&
                    (w_dest[j*REG_ADDR_W +: REG_ADDR_W] == w_dest[i*REG_ADDR_W +: REG_ADDR_W])) begin
                    shadowed[i] = 1'b1;
                end
            end
        end
    end

    assign rf_we      = fire ? (retiring & w_gr_we & ~shadowed) : '0;
    assign rf_waddr   = w_dest;
    assign rf_wdata   = w_result;
    assign retire_cnt = fire ? RC_W'(n_ret) : '0;

    // Exception info comes from the excepting lane, or lane 0 when none.
    always_comb begin
        csr_ecode    = w_ecode[0 +: ECODE_W];
        csr_esubcode = w_esubcode[0];
        csr_pc       = w_pc[0 +: XLEN];
        csr_vaddr    = w_vaddr[0 +: XLEN];
        for (int i = 1; i < LANES; i++) begin
            if (i == ex_lane) begin
                csr_ecode    = w_ecode[i*ECODE_W +: ECODE_W];
                csr_esubcode = w_esubcode[i];
                csr_pc       = w_pc[i*XLEN +: XLEN];
                csr_vaddr    = w_vaddr[i*XLEN +: XLEN];
            end
        end
    end

    assign csr_ex    = fire && (ex_lane < LANES);
    assign csr_we    = fire && w_csr_we && (ex_lane != 0);
    assign csr_addr  = w_csr_addr;
    assign csr_wmask = w_csr_wmask;
    assign csr_wdata = w_csr_wdata;

    // Trace entries for every lane; only the retiring prefix is pushed.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            push_data[i] = {w_pc[i*XLEN +: XLEN], w_gr_we[i],
                            w_dest[i*REG_ADDR_W +: REG_ADDR_W], w_result[i*XLEN +: XLEN]};
        end
    end

    wb_dbg_fifo #(
        .LANES (LANES),
        .DEPTH (DBG_DEPTH),
        .WIDTH (EW)
    ) u_dbg_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push_cnt  (retire_cnt),
        .push_data (push_data),
        .count     (dbg_count),
        .head      (dbg_head)
    );

    assign debug_wb_pc       = dbg_head[EW-1 -: XLEN];
    assign debug_wb_rf_we    = {4{dbg_head[XLEN+REG_ADDR_W]}};
    assign debug_wb_rf_wnum  = dbg_head[XLEN +: REG_ADDR_W];
    assign debug_wb_rf_wdata = dbg_head[XLEN-1:0];

endmodule

// File: tb/tb_wb_commit_multi.sv
// Bench for wb_commit_multi: directed scenarios with literal expectations,
// then randomized groups, all compared every cycle against a queue-based model.
module tb_wb_commit_multi;

    localparam int LANES     = 2;
    localparam int XLEN      = 32;
    localparam int DBG_DEPTH = 4;

    logic                  clk = 1'b0;
    logic                  rstn;
    logic                  w_allowin;
    logic                  mw_valid;
    logic [LANES-1:0]      mw_lane_valid;
    logic [LANES*XLEN-1:0] mw_pc, mw_result, mw_vaddr;
    logic [LANES-1:0]      mw_gr_we;
    logic [LANES*5-1:0]    mw_dest;
    logic [LANES-1:0]      mw_ex;
    logic [LANES*8-1:0]    mw_ecode;
    logic [LANES-1:0]      mw_esubcode;
    logic                  mw_csr_we;
    logic [13:0]           mw_csr_addr;
    logic [XLEN-1:0]       mw_csr_wmask, mw_csr_wdata;
    logic                  ex_en;
    logic [LANES-1:0]      rf_we;
    logic [LANES*5-1:0]    rf_waddr;
    logic [LANES*XLEN-1:0] rf_wdata;
    logic                  csr_ex;
    logic [7:0]            csr_ecode;
    logic                  csr_esubcode;
    logic [XLEN-1:0]       csr_pc, csr_vaddr;
    logic                  csr_we;
    logic [13:0]           csr_addr;
    logic [XLEN-1:0]       csr_wmask, csr_wdata;
    logic [1:0]            retire_cnt;
    logic [XLEN-1:0]       debug_wb_pc;
    logic [3:0]            debug_wb_rf_we;
    logic [4:0]            debug_wb_rf_wnum;
    logic [XLEN-1:0]       debug_wb_rf_wdata;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    wb_commit_multi #(.LANES(LANES), .XLEN(XLEN), .DBG_DEPTH(DBG_DEPTH)) dut (
        .clk(clk), .rstn(rstn), .w_allowin(w_allowin),
        .mw_valid(mw_valid), .mw_lane_valid(mw_lane_valid),
        .mw_pc(mw_pc), .mw_result(mw_result), .mw_vaddr(mw_vaddr),
        .mw_gr_we(mw_gr_we), .mw_dest(mw_dest), .mw_ex(mw_ex),
        .mw_ecode(mw_ecode), .mw_esubcode(mw_esubcode),
        .mw_csr_we(mw_csr_we), .mw_csr_addr(mw_csr_addr),
        .mw_csr_wmask(mw_csr_wmask), .mw_csr_wdata(mw_csr_wdata),
        .ex_en(ex_en),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .csr_ex(csr_ex), .csr_ecode(csr_ecode), .csr_esubcode(csr_esubcode),
        .csr_pc(csr_pc), .csr_vaddr(csr_vaddr),
        .csr_we(csr_we), .csr_addr(csr_addr), .csr_wmask(csr_wmask), .csr_wdata(csr_wdata),
        .retire_cnt(retire_cnt),
        .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we),
        .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
    );

    // ---------------- reference model ----------------
    typedef struct packed {
        logic        lv;
        logic [31:0] pc;
        logic [31:0] res;
        logic [31:0] va;
        logic        we;
        logic [4:0]  dest;
        logic        ex;
        logic [7:0]  ec;
        logic        es;
    } lane_t;

    typedef struct packed {
        logic [31:0] pc;
        logic        we;
        logic [4:0]  dest;
        logic [31:0] res;
    } ent_t;

    lane_t       g [LANES];
    logic        m_valid = 1'b0;
    logic        g_csr_we;
    logic [13:0] g_csr_addr;
    logic [31:0] g_wmask, g_wdata;
    ent_t        q [$];

    function automatic int m_k();
        for (int i = 0; i < LANES; i++) if (g[i].lv && g[i].ex) return i;
        return LANES;
    endfunction

    function automatic int m_nret();
        int n = 0;
        int k = m_k();
        for (int i = 0; i < k; i++) if (g[i].lv) n++;
        return n;
    endfunction

    function automatic bit m_ready();
        return (DBG_DEPTH - q.size()) >= m_nret();
    endfunction

    function automatic bit m_fire();
        return m_valid && m_ready();
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit f;
        int n;
        bit allow;
        ent_t e;
        if (!rstn) begin
            m_valid = 1'b0;
            foreach (g[i]) g[i] = '0;
            g_csr_we = 1'b0; g_csr_addr = '0; g_wmask = '0; g_wdata = '0;
            q.delete();
        end else begin
            f     = m_fire();
            n     = m_nret();
            allow = !m_valid || m_ready();
            if (q.size() > 0) void'(q.pop_front());
            if (f) begin
                for (int i = 0; i < n; i++) begin
                    e.pc = g[i].pc; e.we = g[i].we; e.dest = g[i].dest; e.res = g[i].res;
                    q.push_back(e);
                end
            end
            if (ex_en) begin
                m_valid = 1'b0;
                foreach (g[i]) g[i] = '0;
                g_csr_we = 1'b0;
            end else if (allow) begin
                m_valid = mw_valid;
                if (mw_valid) begin
                    for (int i = 0; i < LANES; i++) begin
                        g[i].lv   = mw_lane_valid[i];
                        g[i].pc   = mw_pc[i*XLEN +: XLEN];
                        g[i].res  = mw_result[i*XLEN +: XLEN];
                        g[i].va   = mw_vaddr[i*XLEN +: XLEN];
                        g[i].we   = mw_gr_we[i];
                        g[i].dest = mw_dest[i*5 +: 5];
                        g[i].ex   = mw_ex[i];
                        g[i].ec   = mw_ecode[i*8 +: 8];
                        g[i].es   = mw_esubcode[i];
                    end
                    g_csr_we = mw_csr_we; g_csr_addr = mw_csr_addr;
                    g_wmask = mw_csr_wmask; g_wdata = mw_csr_wdata;
                end
            end
        end
    endtask

    // Every-cycle comparison of all outputs against the model.
    task automatic compare();
        int k = m_k();
        int n = m_nret();
        bit f = m_fire();
        int last [int];
        logic [LANES-1:0] exp_we = '0;
        int sel;
        ent_t e;
        chk("w_allowin", w_allowin, !m_valid || m_ready());
        // last writer of each register among the retiring lanes wins
        for (int i = 0; i < n; i++) if (g[i].we) last[int'(g[i].dest)] = i;
        for (int i = 0; i < n; i++) if (f && g[i].we && last[int'(g[i].dest)] == i) exp_we[i] = 1'b1;
        chk("rf_we", rf_we, exp_we);
        for (int i = 0; i < LANES; i++) begin
            if (exp_we[i]) begin
                chk("rf_waddr", rf_waddr[i*5 +: 5], g[i].dest);
                chk("rf_wdata", rf_wdata[i*XLEN +: XLEN], g[i].res);
            end
        end
        chk("csr_ex", csr_ex, f && k < LANES);
        if (f && k < LANES) begin
            sel = k;
            chk("csr_pc", csr_pc, g[sel].pc);
            chk("csr_ecode", csr_ecode, g[sel].ec);
            chk("csr_esubcode", csr_esubcode, g[sel].es);
            chk("csr_vaddr", csr_vaddr, g[sel].va);
        end
        chk("csr_we", csr_we, f && g_csr_we && k != 0);
        if (f && g_csr_we && k != 0) begin
            chk("csr_addr", csr_addr, g_csr_addr);
            chk("csr_wmask", csr_wmask, g_wmask);
            chk("csr_wdata", csr_wdata, g_wdata);
        end
        chk("retire_cnt", retire_cnt, f ? n : 0);
        if (q.size() > 0) begin
            e = q[0];
            chk("dbg_pc", debug_wb_pc, e.pc);
            chk("dbg_we", debug_wb_rf_we, {4{e.we}});
            chk("dbg_wnum", debug_wb_rf_wnum, e.dest);
            chk("dbg_wdata", debug_wb_rf_wdata, e.res);
        end else begin
            chk("dbg_empty", {debug_wb_pc, debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata}, 0);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic clear_inputs();
        mw_valid = 0; mw_lane_valid = '0; mw_pc = '0; mw_result = '0; mw_vaddr = '0;
        mw_gr_we = '0; mw_dest = '0; mw_ex = '0; mw_ecode = '0; mw_esubcode = '0;
        mw_csr_we = 0; mw_csr_addr = '0; mw_csr_wmask = '0; mw_csr_wdata = '0; ex_en = 0;
    endtask

    task automatic set_lane(input int i, input logic [31:0] pc, input logic [31:0] res,
                            input logic we, input logic [4:0] dest, input logic ex,
                            input logic [7:0] ec);
        mw_valid = 1'b1;
        mw_lane_valid[i] = 1'b1;
        mw_pc[i*XLEN +: XLEN] = pc;
        mw_result[i*XLEN +: XLEN] = res;
        mw_vaddr[i*XLEN +: XLEN] = pc ^ res;
        mw_gr_we[i] = we;
        mw_dest[i*5 +: 5] = dest;
        mw_ex[i] = ex;
        mw_ecode[i*8 +: 8] = ec;
        mw_esubcode[i] = ec[0];
    endtask

    logic [31:0] pc_ctr = 32'h1c010000;

    task automatic drive_random();
        int nv;
        clear_inputs();
        rstn  = ($urandom_range(299) != 0);
        ex_en = ($urandom_range(15) == 0);
        if ($urandom_range(9) < 7) begin
            nv = $urandom_range(LANES, 1);
            for (int i = 0; i < nv; i++) begin
                set_lane(i, pc_ctr, $urandom, $urandom_range(3) != 0,
                         5'($urandom_range(7)), $urandom_range(5) == 0, 8'($urandom));
                pc_ctr = pc_ctr + 4;
            end
            if (nv == 1 && $urandom_range(3) == 0) begin
                mw_csr_we = 1'b1; mw_csr_addr = 14'($urandom);
                mw_csr_wmask = $urandom; mw_csr_wdata = $urandom;
            end
        end
    endtask

    logic [31:0] seen [$];
    bit          saw_stall;
    int          grp;
    bit          acc;

    initial begin
        clear_inputs();
        rstn = 1'b0;
        tick();
        tick();
        chk("reset_allowin", w_allowin, 1);
        chk("reset_rf_we", rf_we, 0);
        chk("reset_retire", retire_cnt, 0);
        chk("reset_csr_pc", csr_pc, 0);
        chk("reset_rf_wdata", rf_wdata, 0);
        chk("reset_dbg_pc", debug_wb_pc, 0);
        rstn = 1'b1;
        tick();

        // two-lane group, no exception
        set_lane(0, 32'h1c000000, 32'h11, 1, 5'd4, 0, 8'h00);
        set_lane(1, 32'h1c000004, 32'h22, 1, 5'd5, 0, 8'h00);
        tick();
        chk("t1_rf_we", rf_we, 2'b11);
        chk("t1_retire", retire_cnt, 2);
        chk("t1_rf_wdata", rf_wdata, 64'h00000022_00000011);
        clear_inputs();
        tick();
        chk("t1_dbg_pc0", debug_wb_pc, 32'h1c000000);
        chk("t1_dbg_wnum0", debug_wb_rf_wnum, 4);
        chk("t1_dbg_we0", debug_wb_rf_we, 4'hF);
        tick();
        chk("t1_dbg_pc1", debug_wb_pc, 32'h1c000004);
        chk("t1_dbg_wdata1", debug_wb_rf_wdata, 32'h22);
        tick();
        chk("t1_dbg_drained", debug_wb_pc, 0);

        // lane 1 excepts
        set_lane(0, 32'h1c000000, 32'h33, 1, 5'd6, 0, 8'h00);
        set_lane(1, 32'h1c000004, 32'h44, 1, 5'd9, 1, 8'h0B);
        tick();
        chk("t2_rf_we", rf_we, 2'b01);
        chk("t2_csr_ex", csr_ex, 1);
        chk("t2_csr_pc", csr_pc, 32'h1c000004);
        chk("t2_csr_ecode", csr_ecode, 8'h0B);
        chk("t2_retire", retire_cnt, 1);
        clear_inputs();
        tick();
        chk("t2_dbg_pc0", debug_wb_pc, 32'h1c000000);
        tick();
        chk("t2_dbg_only_lane0", debug_wb_pc, 0);

        // lane 0 excepts with a CSR write
        set_lane(0, 32'h1c000008, 32'h55, 1, 5'd3, 1, 8'h08);
        mw_csr_we = 1'b1; mw_csr_addr = 14'h5; mw_csr_wmask = '1; mw_csr_wdata = 32'hABCD;
        tick();
        chk("t3_csr_we", csr_we, 0);
        chk("t3_rf_we", rf_we, 0);
        chk("t3_csr_ex", csr_ex, 1);
        chk("t3_retire", retire_cnt, 0);
        clear_inputs();
        tick();
        chk("t3_no_trace", debug_wb_pc, 0);

        // same-group WAW on r7
        set_lane(0, 32'h1c000020, 32'hA, 1, 5'd7, 0, 8'h00);
        set_lane(1, 32'h1c000024, 32'hB, 1, 5'd7, 0, 8'h00);
        tick();
        chk("t4_rf_we", rf_we, 2'b10);
        chk("t4_rf_wdata1", rf_wdata[63:32], 32'hB);
        clear_inputs();
        tick();
        chk("t4_dbg_wdata0", debug_wb_rf_wdata, 32'hA);
        chk("t4_dbg_we0", debug_wb_rf_we, 4'hF);
        tick();
        chk("t4_dbg_wdata1", debug_wb_rf_wdata, 32'hB);
        chk("t4_dbg_we1", debug_wb_rf_we, 4'hF);

        // back-to-back two-lane groups
        grp = 0;
        saw_stall = 0;
        for (int c = 0; c < 16; c++) begin
            clear_inputs();
            set_lane(0, 32'h1c001000 + 32'(grp * 8), 32'(grp), 1, 5'd1, 0, 8'h00);
            set_lane(1, 32'h1c001004 + 32'(grp * 8), 32'(grp), 1, 5'd2, 0, 8'h00);
            acc = w_allowin;
            if (!acc) saw_stall = 1;
            tick();
            if (acc) grp++;
            if (debug_wb_rf_we != 0) seen.push_back(debug_wb_pc);
        end
        clear_inputs();
        for (int c = 0; c < 10; c++) begin
            tick();
            if (debug_wb_rf_we != 0) seen.push_back(debug_wb_pc);
        end
        chk("t5_stall_seen", saw_stall, 1);
        chk("t5_trace_count", seen.size(), 2 * grp);
        for (int i = 0; i < seen.size(); i++) chk("t5_trace_order", seen[i], 32'h1c001000 + 32'(4 * i));

        // flush alongside a new group, then reset mid-drain
        set_lane(0, 32'h1c002000, 32'h1, 1, 5'd10, 0, 8'h00);
        set_lane(1, 32'h1c002004, 32'h2, 1, 5'd11, 0, 8'h00);
        tick();
        clear_inputs();
        set_lane(0, 32'h1c002008, 32'h3, 1, 5'd12, 0, 8'h00);
        ex_en = 1'b1;
        tick();
        chk("t6_rf_we", rf_we, 0);
        chk("t6_retire", retire_cnt, 0);
        chk("t6_dbg_pc0", debug_wb_pc, 32'h1c002000);
        clear_inputs();
        tick();
        chk("t6_dbg_pc1", debug_wb_pc, 32'h1c002004);
        rstn = 1'b0;
        tick();
        chk("t6_rst_dbg_pc", debug_wb_pc, 0);
        chk("t6_rst_dbg_we", debug_wb_rf_we, 0);
        chk("t6_rst_allowin", w_allowin, 1);
        rstn = 1'b1;
        tick();

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            drive_random();
            tick();
        end
        rstn = 1'b1;
        clear_inputs();
        for (int c = 0; c < 10; c++) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_commit_multi.md
Name: wb_commit_multi

Overview:
- Parametrised successor of the single-lane writeback stage: final pipeline stage for a LANES-wide in-order core.
- Registers a group of up to LANES results from memory stage and commits them in program order.
- Commit covers: per-lane register-file write ports, one CSR/exception port, same-group WAW suppression, retire count.
- A debug-trace FIFO serialises retired instructions to the one-per-cycle difftest/trace port, back-pressuring the stage when full.

Parameters:
- LANES, 2, issue/commit width (1..4); lane 0 is oldest.
- XLEN, 32, data/address width.
- DBG_DEPTH, 4, debug FIFO entries, power of two, >= LANES.

Ports:
- clk in 1 clock; rstn in 1 synchronous active-low reset.
- w_allowin out 1 stage can accept a group.
- mw_valid in 1 group valid from memory stage; mw_lane_valid in LANES per-lane valid, contiguous from lane 0.
- mw_pc, mw_result, mw_vaddr in LANES*XLEN; mw_gr_we in LANES; mw_dest in LANES*5.
- mw_ex in LANES; mw_ecode in LANES*8; mw_esubcode in LANES. Lane i occupies [i*W +: W].
- mw_csr_we in 1; mw_csr_addr in 14; mw_csr_wmask, mw_csr_wdata in XLEN. Lane 0 only; issue never pairs CSR ops.
- ex_en in 1 flush from CSR unit.
- rf_we out LANES; rf_waddr out LANES*5; rf_wdata out LANES*XLEN.
- csr_ex out 1; csr_ecode out 8; csr_esubcode out 1; csr_pc, csr_vaddr out XLEN.
- csr_we out 1; csr_addr out 14; csr_wmask, csr_wdata out XLEN.
- retire_cnt out clog2(LANES+1) instructions retired this cycle.
- debug_wb_pc out XLEN; debug_wb_rf_we out 4; debug_wb_rf_wnum out 5; debug_wb_rf_wdata out XLEN.

Behaviour:
- Reset: stage register, w_valid, FIFO pointers and count cleared. All outputs 0; w_allowin=1.
- Handshake: w_ready_go = (DBG_DEPTH - dbg_count) >= n_ret. dbg_count is the registered count; a same-cycle pop is not credited. w_allowin = !w_valid || w_ready_go. fire = w_valid && w_ready_go.
- Capture when mw_valid && w_allowin; w_valid <= mw_valid when w_allowin.
- ex_en has priority over capture: w_valid <= 0 next edge; payload cleared. FIFO is not flushed and keeps draining.
- Exception: k = lowest valid lane with mw_ex=1, else LANES. Retiring lanes are valid lanes < k; n_ret = their count.
- All commit outputs are gated by fire: rf_we, csr_we, csr_ex, retire_cnt. When stalled, nothing is written and state holds.
- rf_we[i] = fire && i<k && lane valid && gr_we[i] && !(younger retiring lane j>i with gr_we[j] and dest[j]==dest[i]). dest 0 writes pass through; the RF ignores r0.
- csr_ex = fire && k<LANES; csr_ecode, csr_esubcode, csr_pc, csr_vaddr come from lane k (lane 0 fields when no exception).
- csr_we = fire && mw_csr_we && k!=0.
- retire_cnt = fire ? n_ret : 0.
- Latency: group loaded at edge E. Commit outputs are valid in the cycle after E. Retiring lanes are pushed at edge E+1 in lane order. Lane 0 appears on debug the cycle after E+1; lane i appears i cycles later, absent FIFO backlog.
- Debug FIFO: entry = {pc, gr_we, dest, result}. A WAW-suppressed lane is still traced with we=1. Excepting and younger lanes are not pushed.
- Pop one entry per cycle when nonempty. Push and pop in the same cycle are legal. Pointers wrap modulo DBG_DEPTH; count never exceeds DBG_DEPTH.
- Debug outputs: head entry when nonempty; debug_wb_rf_we = {4{gr_we}}. When empty, all debug outputs are 0.
- Non-contiguous mw_lane_valid, or mw_csr_we with LANES>1 valid, is illegal; behaviour undefined.

Decomposition:
- Shared package/defines: LANES_MAX, ECODE_W=8, CSR_ADDR_W=14, REG_ADDR_W=5, the debug entry width macro, and clog2 helper function.
- One sub-module: wb_dbg_fifo (parametrised sync FIFO, multi-push up to LANES per cycle, single pop, exposes count).

Test Plan:
- LANES=2, group {pc 0x1c000000 r4<=0x11, pc 0x1c000004 r5<=0x22}, no ex: rf_we=2'b11, retire_cnt=2. Debug shows pc …000 then …004 on consecutive cycles.
- Lane 1 ex ecode 0x0B: rf_we=2'b01, csr_ex=1, csr_pc=0x1c000004, csr_ecode=0x0B, retire_cnt=1, only lane 0 traced.
- Lane 0 ex with csr_we=1: csr_we=0, rf_we=0, csr_ex=1, nothing pushed.
- Both lanes write r7 (0xA, then 0xB): rf_we=2'b10, rf_wdata lane1=0xB. Both entries traced with we=4'hF.
- DBG_DEPTH=4, back-to-back two-lane groups every cycle: w_allowin drops once count>2. No group lost or duplicated; trace is pc-ordered.
- ex_en asserted together with mw_valid: next cycle w_valid=0, no rf_we. FIFO backlog still drains. rstn low mid-drain empties FIFO and zeros debug outputs next cycle.
